regfile_write_ctrl: RTL

//  Write-back front end for the 32x32 register block.
//  - Accepts register write requests from the write-back stage through a valid/ready handshake.
//  - Buffers them in a small FIFO and retires one per cycle into the register block.

---
 rtl/regfile_write_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: write-back front end for the 32x32 register block.
// Buffers write requests in a DEPTH-entry FIFO, retires one per cycle onto
// the per-register data bus / active-low write controls, and provides two
// combinational read ports over the register block outputs.
// Optional feature: define REGFILE_WR_BYPASS_EN to forward queued writes
// to the read ports (youngest matching entry wins).
module regfile_write_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  output logic [31:0][DW-1:0]      reg_data,
  output logic [31:0]              reg_ctrl,
  input  logic [31:0][DW-1:0]      regs_in,
  input  logic [AW-1:0]            rd_addr_a,
  output logic [DW-1:0]            rd_data_a,
  input  logic [AW-1:0]            rd_addr_b,
  output logic [DW-1:0]            rd_data_b,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NRP = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wrEntry_t;

  wrEntry_t           mem [DEPTH];
  wrEntry_t           head;
  logic [PW-1:0]      rdPtr, wrPtr;
  logic [CW-1:0]      cnt;
  logic               push, pop;
  logic [NRP-1:0][AW-1:0] rdAddr;
  logic [NRP-1:0][DW-1:0] rdData;

  // r0 is hardwired: its requests complete the handshake but never enter the queue
  assign wr_ready = (cnt != CW'(DEPTH));
  assign push     = wr_valid && wr_ready && (wr_addr != '0);
  assign pop      = (cnt != '0);
  assign head     = mem[rdPtr];
  assign busy     = pop;
  assign count    = cnt;

  // Pointer/occupancy state; reset abandons queued and retiring entries alike
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; validity is tracked purely by the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= '{addr: wr_addr, data: wr_data};
  end

  // Retire the head every non-empty cycle: broadcast data, strobe one control low
  always_comb begin
    reg_ctrl = '1;
    reg_data = '0;
    if (pop) begin
      reg_data             = {32{head.data}};
      reg_ctrl[head.addr]  = 1'b0;
    end
    reg_ctrl[0] = 1'b1;
  end

  assign rdAddr = {rd_addr_b, rd_addr_a};
  assign rd_data_a = rdData[0];
  assign rd_data_b = rdData[1];

  // Read ports; with forwarding, scan oldest->youngest so the last match wins
  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      rdData[p] = regs_in[rdAddr[p]];
`ifdef REGFILE_WR_BYPASS_EN
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < cnt) && (mem[rdPtr + PW'(i)].addr == rdAddr[p]))
          rdData[p] = mem[rdPtr + PW'(i)].data;
      end
`endif
      if (rdAddr[p] == '0) rdData[p] = '0;
    end
  end

endmodule
